// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU sizing constants and the program-loader state type.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int OP_SIZE  = 4;
    localparam int ARG_SIZE = 3;
    localparam int ARG_NUM  = 2;
    localparam int ADDR_W   = 6;
    localparam int IW       = OP_SIZE + ARG_NUM * ARG_SIZE;

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_LOAD = 3'd1,
        LD_CSUM = 3'd2,
        LD_RUN  = 3'd3,
        LD_ERR  = 3'd4
    } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/prog_loader_if.sv
// ============================================================================
//  Module      : prog_loader_if
//  Description : Host stream, instruction-memory write port and status of the loader.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface prog_loader_if
    import cpu_pkg::*;
#(
    parameter int IW_P     = cpu_pkg::IW,
    parameter int ADDR_W_P = cpu_pkg::ADDR_W
);
    logic                load_req;
    logic                in_valid;
    logic                in_ready;
    logic [IW_P-1:0]     in_data;
    logic                in_last;
    logic                mem_we;
    logic [ADDR_W_P-1:0] mem_addr;
    logic [IW_P-1:0]     mem_wdata;
    logic                cpu_run;
    logic                load_err;
    logic [ADDR_W_P:0]   word_count;

    modport master (
        output load_req, in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_err, word_count
    );

    modport slave (
        input  load_req, in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_err, word_count
    );

endinterface

`default_nettype wire

// File: rtl/xor_accum.sv
// ============================================================================
//  Module      : xor_accum
//  Description : Clearable XOR accumulator; clr has priority over en.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module xor_accum
    import cpu_pkg::*;
#(
    parameter int W = cpu_pkg::IW
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         clr,
    input  wire logic         en,
    input  wire logic [W-1:0] d,
    output logic      [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= q ^ d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
//  Module      : prog_loader
//  Description : Loads host words into instruction memory, verifies the XOR
//                checksum and releases the CPU only after a clean load.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module prog_loader
    import cpu_pkg::*;
#(
    parameter int OP_SIZE  = cpu_pkg::OP_SIZE,
    parameter int ARG_SIZE = cpu_pkg::ARG_SIZE,
    parameter int ARG_NUM  = cpu_pkg::ARG_NUM,
    parameter int ADDR_W   = cpu_pkg::ADDR_W
) (
    input  wire logic    clk,
    input  wire logic    rst,
    prog_loader_if.slave bus
);

    localparam int IW_L = OP_SIZE + ARG_NUM * ARG_SIZE;

    localparam logic [2:0] S_IDLE = 3'(LD_IDLE);
    localparam logic [2:0] S_LOAD = 3'(LD_LOAD);
    localparam logic [2:0] S_CSUM = 3'(LD_CSUM);
    localparam logic [2:0] S_RUN  = 3'(LD_RUN);
    localparam logic [2:0] S_ERR  = 3'(LD_ERR);

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(1) << ADDR_W;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_in_ready;
    logic              r_cpu_run;
    logic              r_load_err;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [IW_L-1:0]   r_mem_wdata;
    logic [ADDR_W:0]   r_count;
    logic [IW_L-1:0]   w_csum;
    logic              w_hs;
    logic              w_wr;
    logic              w_clr;

    assign w_hs = bus.in_valid & r_in_ready;

    // load_req wins in every state, so a handshake in a restart cycle is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_clr       = 1'b0;
        if (bus.load_req) begin
            w_state_nxt = S_LOAD;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_hs) begin
                        if (r_count == C_DEPTH) begin
                            w_state_nxt = S_ERR;
                        end else begin
                            w_wr = 1'b1;
                            if (bus.in_last) begin
                                w_state_nxt = S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (w_hs) begin
                        w_state_nxt = (bus.in_data == w_csum) ? S_RUN : S_ERR;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    xor_accum #(
        .W (IW_L)
    ) u_csum (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .en  (w_wr),
        .d   (bus.in_data),
        .q   (w_csum)
    );

    // Status flags are decoded from the next state so they are plain registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_cpu_run   <= 1'b0;
            r_load_err  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_count     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_CSUM);
            r_cpu_run  <= (w_state_nxt == S_RUN);
            r_load_err <= (w_state_nxt == S_ERR);
            r_mem_we   <= w_wr;
            if (w_wr) begin
                r_mem_addr  <= r_count[ADDR_W-1:0];
                r_mem_wdata <= bus.in_data;
            end
            if (w_clr) begin
                r_count <= '0;
            end else if (w_wr) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.cpu_run    = r_cpu_run;
    assign bus.load_err   = r_load_err;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.word_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader with a write scoreboard.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_prog_loader;
    import cpu_pkg::*;

    typedef struct {
        int         n;
        logic [9:0] w [4];
        logic [9:0] csum;
        bit         gaps;
        bit         exp_run;
    } vec_t;

    typedef struct {
        logic [5:0] a;
        logic [9:0] d;
    } wr_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   exp_cnt;
    wr_t  sbq [$];
    vec_t vecs [5];

    prog_loader_if bus ();

    prog_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: actual addr=%0h data=%0h required no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_t e;
                e = sbq.pop_front();
                if (bus.mem_addr !== e.a || bus.mem_wdata !== e.d) begin
                    errors++;
                    $display("FAIL mem_write: actual addr=%0h data=%0h required addr=%0h data=%0h",
                             bus.mem_addr, bus.mem_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic send(input logic [9:0] d, input bit last, input bit push);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: actual in_ready=%0b required 1", bus.in_ready);
        end else if (push && exp_cnt < 64) begin
            sbq.push_back('{a: 6'(exp_cnt), d: d});
            exp_cnt++;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        exp_cnt      = 0;
        rst          = 1'b1;
        bus.load_req = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;

        vecs[0] = '{n: 3, w: '{10'h005, 10'h123, 10'h3FF, 10'h000}, csum: 10'h2D9, gaps: 0, exp_run: 1};
        vecs[1] = '{n: 3, w: '{10'h005, 10'h123, 10'h3FF, 10'h000}, csum: 10'h000, gaps: 0, exp_run: 0};
        vecs[2] = '{n: 4, w: '{10'h001, 10'h002, 10'h004, 10'h008}, csum: 10'h00F, gaps: 1, exp_run: 1};
        vecs[3] = '{n: 1, w: '{10'h2AA, 10'h000, 10'h000, 10'h000}, csum: 10'h2AA, gaps: 0, exp_run: 1};
        vecs[4] = '{n: 4, w: '{10'h100, 10'h200, 10'h300, 10'h0FF}, csum: 10'h0FE, gaps: 0, exp_run: 0};

        repeat (3) tick();
        rst = 1'b0;
        check("reset_in_ready", 32'(bus.in_ready), 0);
        check("reset_cpu_run", 32'(bus.cpu_run), 0);
        check("reset_load_err", 32'(bus.load_err), 0);
        check("reset_word_count", 32'(bus.word_count), 0);
        check("reset_mem_we", 32'(bus.mem_we), 0);

        for (int i = 0; i < 5; i++) begin
            pulse_load();
            check($sformatf("v%0d_ready_after_req", i), 32'(bus.in_ready), 1);
            check($sformatf("v%0d_count_cleared", i), 32'(bus.word_count), 0);
            for (int j = 0; j < vecs[i].n; j++) begin
                send(vecs[i].w[j], (j == vecs[i].n - 1), 1'b1);
                if (vecs[i].gaps) tick();
            end
            send(vecs[i].csum, 1'b0, 1'b0);
            check($sformatf("v%0d_cpu_run", i), 32'(bus.cpu_run), 32'(vecs[i].exp_run));
            check($sformatf("v%0d_load_err", i), 32'(bus.load_err), 32'(!vecs[i].exp_run));
            check($sformatf("v%0d_word_count", i), 32'(bus.word_count), 32'(vecs[i].n));
            check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 0);
        end

        // Overflow: 65 words with no last marker.
        pulse_load();
        for (int j = 0; j < 65; j++) begin
            send(10'(j * 7 + 1), 1'b0, 1'b1);
        end
        tick();
        check("ovf_load_err", 32'(bus.load_err), 1);
        check("ovf_word_count", 32'(bus.word_count), 64);
        check("ovf_in_ready", 32'(bus.in_ready), 0);
        check("ovf_cpu_run", 32'(bus.cpu_run), 0);

        // Reload from RUN drops cpu_run on the load_req edge.
        pulse_load();
        send(10'h155, 1'b1, 1'b1);
        send(10'h155, 1'b0, 1'b0);
        check("run1_cpu_run", 32'(bus.cpu_run), 1);
        pulse_load();
        check("reload_cpu_run_drop", 32'(bus.cpu_run), 0);
        check("reload_word_count", 32'(bus.word_count), 0);
        send(10'h0C3, 1'b1, 1'b1);
        send(10'h0C3, 1'b0, 1'b0);
        check("reload_cpu_run", 32'(bus.cpu_run), 1);
        check("reload_word_count_1", 32'(bus.word_count), 1);

        // Restart mid-load: handshake in the load_req cycle is discarded.
        pulse_load();
        send(10'h011, 1'b0, 1'b1);
        bus.load_req = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 10'h3C3;
        tick();
        bus.load_req = 1'b0;
        bus.in_valid = 1'b0;
        exp_cnt      = 0;
        check("restart_word_count", 32'(bus.word_count), 0);
        send(10'h022, 1'b1, 1'b1);
        send(10'h022, 1'b0, 1'b0);
        check("restart_cpu_run", 32'(bus.cpu_run), 1);

        // Reset in the middle of a load.
        pulse_load();
        send(10'h0AA, 1'b0, 1'b1);
        send(10'h055, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_in_ready", 32'(bus.in_ready), 0);
        check("rst_mid_cpu_run", 32'(bus.cpu_run), 0);
        check("rst_mid_load_err", 32'(bus.load_err), 0);
        check("rst_mid_word_count", 32'(bus.word_count), 0);
        check("rst_mid_mem_we", 32'(bus.mem_we), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 10'h1FF;
        repeat (3) tick();
        check("idle_ignores_valid", 32'(bus.in_ready), 0);
        bus.in_valid = 1'b0;

        repeat (3) tick();
        check("scoreboard_drained", 32'(sbq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Host-side program loader that fills the 64-entry instruction memory before the CPU runs. Accepts 10-bit instruction words from a host over a valid/ready stream, writes them to consecutive instruction-memory addresses from 0, and checks a trailing XOR checksum word. Only after a clean load does it assert `cpu_run`, which the top level uses to release the CPU FSM and PC from reset. It is the write end of the instruction memory that the PC/fetch path reads.

## Interface
Parameters:
- `OP_SIZE`, 4, opcode field width.
- `ARG_SIZE`, 3, argument field width.
- `ARG_NUM`, 2, arguments per instruction.
- `ADDR_W`, 6, instruction-memory address width; depth = 2^ADDR_W = 64.
- Instruction width `IW = OP_SIZE + ARG_NUM*ARG_SIZE` = 10.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_req`  in  1  single-cycle pulse that starts a (re)load.
- `in_valid`  in  1  host word valid.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  IW  instruction or checksum word.
- `in_last`  in  1  marks the final instruction word. Not used on the checksum word.
- `mem_we`  out  1  instruction-memory write strobe.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  IW  write data.
- `cpu_run`  out  1  1 means the CPU may execute. The CPU is held in reset while this is 0.
- `load_err`  out  1  sticky error: bad checksum or overflow.
- `word_count`  out  ADDR_W+1  instructions written in the current load (0..64).

## Operation
- **States:** IDLE, LOAD, CSUM, RUN, ERR. State after reset is IDLE.
- **Reset values:** every output is 0. The checksum register is also 0.
- **IDLE:** `in_ready`=0. `load_req` moves to LOAD, clears `word_count`, the checksum and `load_err`.
- **LOAD:** `in_ready`=1. On each handshake (`in_valid & in_ready`):
  - write `in_data` at address `word_count[ADDR_W-1:0]`;
  - set checksum ^= `in_data`;
  - `word_count`++.
  - If `in_last`=1 on that word, go to CSUM.
- **Overflow:** a handshake with `word_count`==64 goes to ERR. That word is not written and is not counted.
- **CSUM:** `in_ready`=1. The next handshake compares `in_data` with the checksum.
  - Equal: go to RUN.
  - Not equal: go to ERR and set `load_err`.
- **RUN:** `cpu_run`=1, `in_ready`=0. `load_req` goes to LOAD with the same clears as IDLE, and `cpu_run` drops on that edge.
- **ERR:** `load_err`=1, `cpu_run`=0, `in_ready`=0. Only `load_req` or `rst` leaves this state; `load_req` goes to LOAD.
- **`load_req` during LOAD or CSUM:** restart. Counters and checksum are cleared, the state stays or returns to LOAD, and a handshake in that same cycle is discarded.
- **`rst` mid-load:** return to IDLE with all outputs 0. Already-written memory contents are not cleared.
- **`in_valid` outside LOAD/CSUM:** ignored, since `in_ready`=0.

## Timing
- `in_ready` is a registered state decode and does not depend combinationally on `in_valid`.
- A handshake is accepted at the same edge at which it is sampled. Sustained throughput is 1 word/cycle.
- The write is registered:
  - `mem_we`, `mem_addr` and `mem_wdata` are valid in the cycle after the handshake, for exactly one cycle.
  - `mem_we`=0 otherwise.
- Checksum result: `cpu_run` or `load_err` rises on the edge that accepts the checksum word, i.e. one cycle after that handshake is presented.
- The final instruction write (`mem_we`) and the checksum acceptance can coincide. Because the write precedes `cpu_run`, memory is complete before the CPU leaves reset.
- `word_count` updates on the handshake edge.

## Structure
- Shared package `cpu_pkg`:
  - `OP_SIZE`, `ARG_SIZE`, `ARG_NUM`, `ADDR_W`;
  - the derived `IW`;
  - the loader state enum type.
- Single sub-module `xor_accum`: a clearable IW-bit XOR accumulator with `clr` and `en` inputs. It is reusable by the memory-integrity checks.
- FSM, counter and write register live in `prog_loader`.

## Test plan
- Reset, then `load_req`, then 3 words 0x005, 0x123, 0x3FF (`in_last` on the third), then checksum 0x2D9:
  - `mem_we` pulses with address/data 0/0x005, 1/0x123, 2/0x3FF;
  - `cpu_run`=1 one cycle after the checksum handshake;
  - `word_count`=3.
- Same load with checksum 0x000: `load_err`=1, `cpu_run` stays 0, state ERR, `in_ready`=0.
- 65 words with no `in_last`: 64 writes at addresses 0..63, then ERR on the 65th handshake with no 65th write; `word_count`=64.
- Host deasserts `in_valid` every other cycle during a 4-word load: writes are gap-tolerant, addresses remain contiguous 0..3, and the checksum is still correct.
- In RUN, pulse `load_req`: `cpu_run` falls on that edge, `word_count`=0, and a new 1-word load with correct checksum returns to RUN.
- Assert `rst` after 2 words of a load: next cycle all outputs are 0 and state is IDLE; `in_ready`=0 until `load_req`.
